ps2_cmd_decoder: RTL and testbench
==================================

Name: ps2_cmd_decoder

Overview:
Parametrised command decoder between the PS/2 `keyboard` receiver and the Game-of-life control path. It consumes the scancode byte stream and handles E0 (extended) and F0 (break) prefixes. It runs an explicit run-mode FSM, accepts multi-digit decimal pattern IDs, and produces stretched control pulses. In manual mode it produces cursor-move pulses with its own auto-repeat, replacing the keyboard's typematic repeat.

Parameters:
ID_W, 16, width of file_id.
MAX_ID, 99, largest enterable pattern ID (must be < 2^ID_W).
HOLD_CYCLES, 65536, cycles each start/pause/clear pulse stays high (>=1).
REPEAT_DELAY, 25000000, cycles a direction is held before the first auto-repeat (0.5 s at 50 MHz).
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats.

Ports:
clk_in  in  1  50 MHz system clock
reset  in  1  asynchronous active-high reset
scancode  in  8  byte from the keyboard receiver
scancode_valid  in  1  one-cycle strobe; scancode valid this cycle (back-to-back strobes allowed)
mode  out  2  0=STOPPED 1=RUNNING 2=PAUSED 3=MANUAL
running  out  1  mode==RUNNING
manual  out  1  mode==MANUAL
start  out  1  stretched start pulse
pause  out  1  stretched pause pulse
clear  out  1  stretched clear pulse
move  out  4  one-cycle move pulse, one-hot: bit0=A/Left, bit1=W/Up, bit2=S/Down, bit3=D/Right
file_id  out  ID_W  committed pattern ID

Behaviour:
- Reset (async): mode=STOPPED; all outputs 0; parser=IDLE; entry accumulator=0; held/repeat state cleared; counters 0.
- Parser FSM, advanced only on scancode_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> plain make event.
  - EXT: F0 -> EXT_BRK; any other byte -> extended make event, back to IDLE.
  - BRK: byte -> plain break event, back to IDLE.
  - EXT_BRK: byte -> extended break event, back to IDLE.
  - Events fire in the same cycle as the final byte's strobe; the FSM registers take effect on the next cycle.
- Plain make codes:
  - 0-9 (45,16,1E,26,25,2E,36,3D,3E,46) -> digit.
  - 76 Esc -> entry clear.
  - 5A Enter -> start.
  - 4D P -> pause.
  - 2D R -> clear.
  - 3A M -> manual.
  - 31 N -> leave manual.
  - 1C/1D/1B/23 A/W/S/D -> direction.
- Extended make codes 6B/75/72/74 (arrow keys) -> direction, same bits as A/W/S/D.
- All other codes are ignored. Break events matter only for direction keys.
- Mode FSM:
  - STOPPED: start -> RUNNING; manual -> MANUAL; clear -> STOPPED.
  - RUNNING: pause -> PAUSED; clear -> STOPPED; start and manual ignored.
  - PAUSED: start -> RUNNING; manual -> MANUAL; clear -> STOPPED.
  - MANUAL: start -> RUNNING; N -> STOPPED with no pulse; clear -> STOPPED.
- Pulses: a *taken* start, pause or clear transition raises the matching output for exactly HOLD_CYCLES cycles, starting the cycle after the event.
  - start, pause and clear are mutually exclusive: a new one cancels the current one and restarts the count.
  - The counter runs only while a pulse is active.
  - Ignored commands produce no pulse.
- Digit entry:
  - acc_next = acc*10 + d. If acc_next > MAX_ID, acc <= d instead (wrap to the last digit).
  - Esc sets acc <= 0.
  - Digits and Esc are accepted in every mode.
  - file_id <= acc every cycle that mode != RUNNING; it is frozen while RUNNING and picks up acc after leaving RUNNING.
- Direction keys (act only when mode==MANUAL):
  - A fresh make (direction not already held) pulses the move bit for 1 cycle, marks the key held, makes it the repeat key, and loads the repeat counter with REPEAT_DELAY.
  - A make for an already-held direction (keyboard typematic repeat) produces no pulse.
  - A break clears that key's held flag. If it was the repeat key, repeat stops.
  - While the repeat key is held: when the counter expires, pulse its move bit and reload with REPEAT_PERIOD.
  - Leaving MANUAL clears all held flags and the repeat state. Direction events outside MANUAL are ignored, and breaks still clear held flags.
- A move pulse from a fresh make wins over a repeat expiry in the same cycle; the repeat counter reloads REPEAT_DELAY.

Decomposition:
- Package game_pkg:
  - mode_t enum (STOPPED/RUNNING/PAUSED/MANUAL).
  - Scancode localparams: SC_E0, SC_F0, digits, commands, WASD, arrows.
  - Direction bit indices DIR_A/W/S/D.
- Sub-module ps2_prefix_parser: the 4-state parser. It outputs event_valid, is_break, is_ext and code[7:0].
- The mode FSM, pulse stretcher, digit accumulator and repeat logic live in the top block.

Test Plan (bench params HOLD_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, MAX_ID=99):
- Reset, then 5A -> mode=1, start high exactly 8 cycles. Then 4D -> start drops the next cycle, pause high 8 cycles, mode=2.
- Digits 1E,26 (2,3) in STOPPED -> file_id=23. Then 16 (1) -> 231>99, so file_id=1. Then 76 -> file_id=0.
- Sequence 5A, then 2E (5) while RUNNING -> file_id unchanged. Then 2D -> mode=0, clear 8 cycles, file_id=5.
- Sequence 3A, then E0 75 -> move=0010 for one cycle. Hold 40 cycles -> repeats at +20, +25, +30, +35. Send 1D typematic makes in between -> no extra pulses. Then E0 F0 75 -> repeats stop.
- 1C in STOPPED -> move stays 0. 4D in STOPPED -> no pause pulse, mode=0. F0 5A -> no start.
- Assert reset mid-pulse and during repeat -> all outputs 0 asynchronously. After release, 5A -> normal start.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and PS/2 set-2 scancode constants for the Game-of-life keyboard path.
package game_pkg;

    typedef enum logic [1:0] {
        MODE_STOPPED = 2'd0,
        MODE_RUNNING = 2'd1,
        MODE_PAUSED  = 2'd2,
        MODE_MANUAL  = 2'd3
    } mode_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    localparam logic [7:0] SC_0     = 8'h45;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_4     = 8'h25;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_7     = 8'h3D;
    localparam logic [7:0] SC_8     = 8'h3E;
    localparam logic [7:0] SC_9     = 8'h46;

    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_N     = 8'h31;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [1:0] DIR_A = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [3:0] val;
    } digit_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } dir_t;

    function automatic digit_t decode_digit(input logic [7:0] code);
        digit_t r;
        r = '0;
        r.hit = 1'b1;
        case (code)
            SC_0:    r.val = 4'd0;
            SC_1:    r.val = 4'd1;
            SC_2:    r.val = 4'd2;
            SC_3:    r.val = 4'd3;
            SC_4:    r.val = 4'd4;
            SC_5:    r.val = 4'd5;
            SC_6:    r.val = 4'd6;
            SC_7:    r.val = 4'd7;
            SC_8:    r.val = 4'd8;
            SC_9:    r.val = 4'd9;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    // WASD and the arrow keys share direction bits; arrows only count when E0-prefixed.
    function automatic dir_t decode_dir(input logic [7:0] code, input logic ext);
        dir_t r;
        r = '0;
        r.hit = 1'b1;
        if (!ext) begin
            case (code)
                SC_A:    r.idx = DIR_A;
                SC_W:    r.idx = DIR_W;
                SC_S:    r.idx = DIR_S;
                SC_D:    r.idx = DIR_D;
                default: r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_LEFT:  r.idx = DIR_A;
                SC_UP:    r.idx = DIR_W;
                SC_DOWN:  r.idx = DIR_S;
                SC_RIGHT: r.idx = DIR_D;
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_prefix_parser.sv
// Folds E0 / F0 prefix bytes into single make/break events tagged extended or plain.
module ps2_prefix_parser import game_pkg::*; (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] scancode,
    input  logic       scancode_valid,
    output logic       event_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic [7:0] code
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    always_comb begin
        state_nxt   = state;
        event_valid = 1'b0;
        if (scancode_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scancode == SC_E0)      state_nxt = ST_EXT;
                    else if (scancode == SC_F0) state_nxt = ST_BRK;
                    else                        event_valid = 1'b1;
                end
                ST_EXT: begin
                    if (scancode == SC_F0) begin
                        state_nxt = ST_EXT_BRK;
                    end else begin
                        event_valid = 1'b1;
                        state_nxt   = ST_IDLE;
                    end
                end
                default: begin
                    event_valid = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Event flags describe the prefix state the final byte arrived in.
    assign is_break = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign is_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign code     = scancode;

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Keyboard command decoder: run-mode FSM, stretched control pulses, decimal pattern-ID
// entry and manual-mode cursor moves with locally generated auto-repeat.
module ps2_cmd_decoder import game_pkg::*; #(
    parameter int ID_W          = 16,
    parameter int MAX_ID        = 99,
    parameter int HOLD_CYCLES   = 65536,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic            clk_in,
    input  logic            reset,
    input  logic [7:0]      scancode,
    input  logic            scancode_valid,
    output logic [1:0]      mode,
    output logic            running,
    output logic            manual,
    output logic            start,
    output logic            pause,
    output logic            clear,
    output logic [3:0]      move,
    output logic [ID_W-1:0] file_id
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 2);

    function automatic logic [ID_W-1:0] acc_push(input logic [ID_W-1:0] a, input logic [3:0] d);
        logic [ID_W+3:0] v;
        v = ({4'b0, a} << 3) + ({4'b0, a} << 1) + {{ID_W{1'b0}}, d};
        if (v > (ID_W+4)'(MAX_ID)) acc_push = ID_W'(d);
        else                       acc_push = v[ID_W-1:0];
    endfunction

    logic       ev_valid;
    logic       ev_break;
    logic       ev_ext;
    logic [7:0] ev_code;

    ps2_prefix_parser u_parser (
        .clk_in         (clk_in),
        .reset          (reset),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .event_valid    (ev_valid),
        .is_break       (ev_break),
        .is_ext         (ev_ext),
        .code           (ev_code)
    );

    digit_t dig;
    dir_t   dir;
    logic   plain_make;
    logic   cmd_start, cmd_pause, cmd_clear, cmd_manual, cmd_leave, cmd_esc, cmd_digit;
    logic   dir_make, dir_brk;

    assign dig        = decode_digit(ev_code);
    assign dir        = decode_dir(ev_code, ev_ext);
    assign plain_make = ev_valid && !ev_break && !ev_ext;
    assign cmd_start  = plain_make && (ev_code == SC_ENTER);
    assign cmd_pause  = plain_make && (ev_code == SC_P);
    assign cmd_clear  = plain_make && (ev_code == SC_R);
    assign cmd_manual = plain_make && (ev_code == SC_M);
    assign cmd_leave  = plain_make && (ev_code == SC_N);
    assign cmd_esc    = plain_make && (ev_code == SC_ESC);
    assign cmd_digit  = plain_make && dig.hit;
    assign dir_make   = ev_valid && dir.hit && !ev_break;
    assign dir_brk    = ev_valid && dir.hit && ev_break;

    mode_t mode_q, mode_nxt;
    logic  take_start, take_pause, take_clear;

    always_comb begin
        mode_nxt   = mode_q;
        take_start = 1'b0;
        take_pause = 1'b0;
        take_clear = 1'b0;
        if (cmd_clear) begin
            mode_nxt   = MODE_STOPPED;
            take_clear = 1'b1;
        end else if (cmd_start && (mode_q != MODE_RUNNING)) begin
            mode_nxt   = MODE_RUNNING;
            take_start = 1'b1;
        end else if (cmd_pause && (mode_q == MODE_RUNNING)) begin
            mode_nxt   = MODE_PAUSED;
            take_pause = 1'b1;
        end else if (cmd_manual && ((mode_q == MODE_STOPPED) || (mode_q == MODE_PAUSED))) begin
            mode_nxt   = MODE_MANUAL;
        end else if (cmd_leave && (mode_q == MODE_MANUAL)) begin
            mode_nxt   = MODE_STOPPED;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) mode_q <= MODE_STOPPED;
        else       mode_q <= mode_nxt;
    end

    assign mode    = mode_q;
    assign running = (mode_q == MODE_RUNNING);
    assign manual  = (mode_q == MODE_MANUAL);

    // One shared counter: a newly taken command replaces whichever pulse is active.
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            start    <= 1'b0;
            pause    <= 1'b0;
            clear    <= 1'b0;
            hold_cnt <= '0;
        end else if (take_start || take_pause || take_clear) begin
            start    <= take_start;
            pause    <= take_pause;
            clear    <= take_clear;
            hold_cnt <= HOLD_W'(HOLD_CYCLES - 1);
        end else if (start || pause || clear) begin
            if (hold_cnt == '0) begin
                start <= 1'b0;
                pause <= 1'b0;
                clear <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    logic [ID_W-1:0] acc;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            file_id <= '0;
        end else begin
            if (cmd_esc)        acc <= '0;
            else if (cmd_digit) acc <= acc_push(acc, dig.val);
            if (mode_q != MODE_RUNNING) file_id <= acc;
        end
    end

    logic [3:0]       held;
    logic             rep_on;
    logic [1:0]       rep_idx;
    logic [REP_W-1:0] rep_cnt;
    logic             stay_manual;
    logic             fresh;
    logic             rep_stop;

    assign stay_manual = (mode_q == MODE_MANUAL) && (mode_nxt == MODE_MANUAL);
    assign fresh       = stay_manual && dir_make && !held[dir.idx];
    assign rep_stop    = dir_brk && rep_on && (rep_idx == dir.idx);

    // Repeat expiry is detected at count 1 so the pulse lands exactly DELAY/PERIOD cycles later.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            move    <= '0;
            held    <= '0;
            rep_on  <= 1'b0;
            rep_idx <= '0;
            rep_cnt <= '0;
        end else begin
            move <= '0;
            if (!stay_manual) begin
                held    <= '0;
                rep_on  <= 1'b0;
                rep_cnt <= '0;
            end else if (fresh) begin
                move[dir.idx] <= 1'b1;
                held[dir.idx] <= 1'b1;
                rep_on        <= 1'b1;
                rep_idx       <= dir.idx;
                rep_cnt       <= REP_W'(REPEAT_DELAY);
            end else begin
                if (dir_brk) held[dir.idx] <= 1'b0;
                if (rep_stop) begin
                    rep_on <= 1'b0;
                end else if (rep_on) begin
                    if (rep_cnt <= REP_W'(1)) begin
                        move[rep_idx] <= 1'b1;
                        rep_cnt       <= REP_W'(REPEAT_PERIOD);
                    end else begin
                        rep_cnt <= rep_cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Bench for ps2_cmd_decoder: directed vector table, hand-written timing sequences and a
// random byte stream compared every cycle against a timestamp-based reference model.
module tb_ps2_cmd_decoder;

    localparam int H     = 8;
    localparam int D     = 20;
    localparam int P     = 5;
    localparam int MAXID = 99;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  scancode = 8'h00;
    logic        scancode_valid = 1'b0;
    logic [1:0]  mode;
    logic        running, manual, start, pause, clear;
    logic [3:0]  move;
    logic [15:0] file_id;

    ps2_cmd_decoder #(
        .ID_W(16), .MAX_ID(MAXID), .HOLD_CYCLES(H), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .clk_in(clk_in), .reset(reset), .scancode(scancode), .scancode_valid(scancode_valid),
        .mode(mode), .running(running), .manual(manual), .start(start), .pause(pause),
        .clear(clear), .move(move), .file_id(file_id)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: prefix flags, abstract mode number, pulse end timestamp and
    // absolute time of the next auto-repeat.
    int       digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    int       m_cyc = 0;
    int       m_mode, m_kind, m_pend, m_acc, m_fid, m_rkey, m_next;
    bit       m_pe, m_pb;
    bit [3:0] m_held, m_move;

    function automatic int dig_of(input logic [7:0] b);
        for (int i = 0; i < 10; i++) if (digit_codes[i] == int'(b)) return i;
        return -1;
    endfunction

    function automatic int dir_of(input logic [7:0] b, input bit ext);
        if (!ext) begin
            case (b)
                8'h1C: return 0;
                8'h1D: return 1;
                8'h1B: return 2;
                8'h23: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h6B: return 0;
            8'h75: return 1;
            8'h72: return 2;
            8'h74: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_pe = 0; m_pb = 0; m_mode = 0; m_kind = 0; m_pend = -1;
        m_acc = 0; m_fid = 0; m_held = 0; m_move = 0; m_rkey = -1; m_next = 0;
    endtask

    task automatic pulse(input int k);
        m_kind = k;
        m_pend = m_cyc + H - 1;
    endtask

    task automatic model_step();
        bit ev, ext, brk;
        int pre, d, k, v;
        logic [7:0] b;
        m_cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        b = scancode; ev = 0; ext = 0; brk = 0;
        if (scancode_valid) begin
            if (!m_pe && !m_pb) begin
                if (b == 8'hE0)      m_pe = 1;
                else if (b == 8'hF0) m_pb = 1;
                else                 ev = 1;
            end else if (m_pe && !m_pb) begin
                if (b == 8'hF0) m_pb = 1;
                else begin ev = 1; ext = 1; m_pe = 0; end
            end else begin
                ev = 1; ext = m_pe; brk = 1; m_pe = 0; m_pb = 0;
            end
        end
        pre = m_mode;
        if (pre != 1) m_fid = m_acc;
        if (ev && !ext && !brk) begin
            d = dig_of(b);
            if (d >= 0) begin
                v = m_acc * 10 + d;
                m_acc = (v > MAXID) ? d : v;
            end
            case (b)
                8'h76: m_acc = 0;
                8'h5A: if (pre != 1) begin m_mode = 1; pulse(1); end
                8'h4D: if (pre == 1) begin m_mode = 2; pulse(2); end
                8'h2D: begin m_mode = 0; pulse(3); end
                8'h3A: if (pre == 0 || pre == 2) m_mode = 3;
                8'h31: if (pre == 3) m_mode = 0;
                default: ;
            endcase
        end
        m_move = 0;
        if (pre == 3 && m_mode == 3) begin
            k = ev ? dir_of(b, ext) : -1;
            if (k >= 0 && !brk && !m_held[k]) begin
                m_move[k] = 1; m_held[k] = 1; m_rkey = k; m_next = m_cyc + D;
            end else begin
                if (k >= 0 && brk) begin
                    m_held[k] = 0;
                    if (m_rkey == k) m_rkey = -1;
                end
                if (m_rkey >= 0 && m_cyc == m_next) begin
                    m_move[m_rkey] = 1;
                    m_next = m_next + P;
                end
            end
        end else begin
            m_held = 0; m_rkey = -1;
        end
    endtask

    task automatic check_model();
        logic s, p, c;
        logic [26:0] act, exp;
        s = (m_kind == 1) && (m_cyc <= m_pend);
        p = (m_kind == 2) && (m_cyc <= m_pend);
        c = (m_kind == 3) && (m_cyc <= m_pend);
        act = {mode, running, manual, start, pause, clear, move, file_id};
        exp = {2'(m_mode), m_mode == 1, m_mode == 3, s, p, c, m_move, 16'(m_fid)};
        chk($sformatf("model cyc%0d {mode,run,man,st,pa,cl,move,id}", m_cyc), 32'(act), 32'(exp));
    endtask

    task automatic step(input logic [7:0] b, input logic v);
        scancode = b;
        scancode_valid = v;
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        scancode_valid = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        step(b, 1'b1);
    endtask

    task automatic async_reset_check(input string name);
        #2 reset = 1'b1;
        model_reset();
        #1 chk(name, 32'({mode, running, manual, start, pause, clear, move, file_id}), 32'd0);
        @(negedge clk_in);
        idle(2);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic [2:0]  pls;
        logic [1:0]  md;
        logic [15:0] fid;
    } vec_t;

    vec_t vecs [28];

    function automatic logic [7:0] pick_byte();
        int r;
        int dirs [8] = '{8'h1C, 8'h1D, 8'h1B, 8'h23, 8'h6B, 8'h75, 8'h72, 8'h74};
        r = $urandom_range(0, 99);
        if (r < 10) return 8'hE0;
        if (r < 18) return 8'hF0;
        if (r < 45) return 8'(dirs[$urandom_range(0, 7)]);
        if (r < 55) return 8'h3A;
        if (r < 60) return 8'h5A;
        if (r < 62) return 8'h2D;
        if (r < 65) return 8'h4D;
        if (r < 67) return 8'h31;
        if (r < 82) return 8'(digit_codes[$urandom_range(0, 9)]);
        if (r < 85) return 8'h76;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int cnt;
        int offs [$];
        int exp_offs [4] = '{20, 25, 30, 35};
        logic [3:0] move_or;

        vecs[0]  = '{24'h1E0000, 1, 3'b000, 2'd0, 16'd2};
        vecs[1]  = '{24'h260000, 1, 3'b000, 2'd0, 16'd23};
        vecs[2]  = '{24'h160000, 1, 3'b000, 2'd0, 16'd1};
        vecs[3]  = '{24'h760000, 1, 3'b000, 2'd0, 16'd0};
        vecs[4]  = '{24'h2E0000, 1, 3'b000, 2'd0, 16'd5};
        vecs[5]  = '{24'h5A0000, 1, 3'b100, 2'd1, 16'd5};
        vecs[6]  = '{24'h3D0000, 1, 3'b000, 2'd1, 16'd5};
        vecs[7]  = '{24'h3A0000, 1, 3'b000, 2'd1, 16'd5};
        vecs[8]  = '{24'h5A0000, 1, 3'b000, 2'd1, 16'd5};
        vecs[9]  = '{24'h4D0000, 1, 3'b010, 2'd2, 16'd57};
        vecs[10] = '{24'h3A0000, 1, 3'b000, 2'd3, 16'd57};
        vecs[11] = '{24'h310000, 1, 3'b000, 2'd0, 16'd57};
        vecs[12] = '{24'hF05A00, 2, 3'b000, 2'd0, 16'd57};
        vecs[13] = '{24'hE05A00, 2, 3'b000, 2'd0, 16'd57};
        vecs[14] = '{24'h4D0000, 1, 3'b000, 2'd0, 16'd57};
        vecs[15] = '{24'h2D0000, 1, 3'b001, 2'd0, 16'd57};
        vecs[16] = '{24'h450000, 1, 3'b000, 2'd0, 16'd0};
        vecs[17] = '{24'h3A0000, 1, 3'b000, 2'd3, 16'd0};
        vecs[18] = '{24'h5A0000, 1, 3'b100, 2'd1, 16'd0};
        vecs[19] = '{24'h2D0000, 1, 3'b001, 2'd0, 16'd0};
        vecs[20] = '{24'h3A0000, 1, 3'b000, 2'd3, 16'd0};
        vecs[21] = '{24'hE0F03A, 3, 3'b000, 2'd3, 16'd0};
        vecs[22] = '{24'h2D0000, 1, 3'b001, 2'd0, 16'd0};
        vecs[23] = '{24'h460000, 1, 3'b000, 2'd0, 16'd9};
        vecs[24] = '{24'h3E0000, 1, 3'b000, 2'd0, 16'd98};
        vecs[25] = '{24'h460000, 1, 3'b000, 2'd0, 16'd9};
        vecs[26] = '{24'h460000, 1, 3'b000, 2'd0, 16'd99};
        vecs[27] = '{24'h450000, 1, 3'b000, 2'd0, 16'd0};

        model_reset();
        @(negedge clk_in);
        idle(2);
        chk("reset mode", 32'(mode), 32'd0);
        chk("reset pulses", 32'({start, pause, clear}), 32'd0);
        chk("reset move", 32'(move), 32'd0);
        chk("reset file_id", 32'(file_id), 32'd0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 28; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send(vecs[i].bytes[23-8*j -: 8]);
            chk($sformatf("vec%0d pulses", i), 32'({start, pause, clear}), 32'(vecs[i].pls));
            idle(10);
            chk($sformatf("vec%0d mode", i), 32'(mode), 32'(vecs[i].md));
            chk($sformatf("vec%0d file_id", i), 32'(file_id), 32'(vecs[i].fid));
        end

        // start pulse width, then pause cancelling a live start pulse
        send(8'h5A);
        cnt = int'(start);
        repeat (11) begin idle(1); cnt += int'(start); end
        chk("start width", 32'(cnt), 32'(H));
        chk("start mode", 32'(mode), 32'd1);
        send(8'h2D);
        idle(10);
        send(8'h5A);
        idle(2);
        send(8'h4D);
        chk("pause cancels start", 32'({start, pause}), 32'b01);
        cnt = 1;
        repeat (11) begin idle(1); cnt += int'(pause); end
        chk("pause width", 32'(cnt), 32'(H));
        chk("pause mode", 32'(mode), 32'd2);

        // manual arrow-up with auto-repeat and ignored typematic makes
        send(8'h3A);
        idle(2);
        send(8'hE0);
        send(8'h75);
        chk("fresh move", 32'(move), 32'b0010);
        for (int i = 1; i < 40; i++) begin
            if (i == 7 || i == 22) send(8'h1D);
            else idle(1);
            if (move != 4'b0000) begin
                offs.push_back(i);
                chk($sformatf("repeat bits @%0d", i), 32'(move), 32'b0010);
            end
        end
        chk("repeat count", 32'(offs.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < offs.size()) chk($sformatf("repeat offset %0d", i), 32'(offs[i]), 32'(exp_offs[i]));
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        move_or = '0;
        for (int i = 0; i < 30; i++) begin idle(1); move_or |= move; end
        chk("repeat stopped", 32'(move_or), 32'd0);

        // direction keys outside manual
        send(8'h2D);
        idle(10);
        send(8'h1C);
        move_or = move;
        for (int i = 0; i < 25; i++) begin idle(1); move_or |= move; end
        chk("no move when stopped", 32'(move_or), 32'd0);

        // async reset during repeat and mid-pulse
        send(8'h3A);
        send(8'h1C);
        chk("fresh move A", 32'(move), 32'b0001);
        idle(22);
        async_reset_check("async reset in repeat");
        send(8'h5A);
        idle(3);
        async_reset_check("async reset mid-pulse");
        send(8'h5A);
        chk("start after reset", 32'({mode, start}), 32'b011);
        idle(10);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 8) idle($urandom_range(1, 30));
            else send(pick_byte());
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
